// File: rtl/seq_arith_unit.sv
// Self-sequencing W-bit arithmetic unit: add, sub, signed Booth multiply, unsigned restoring divide.
// Optional build macro SEQ_ARITH_DIVZERO_EN adds a div_zero flag and a short divide-by-zero path.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; latches op/a/b and seeds the datapath
// S_ARITH | single-cycle add/sub (also the divide-by-zero path when enabled)
// S_ITER  | W Booth-multiply or restoring-divide iterations
// S_DONE  | done pulse, result valid; returns to S_IDLE
module seq_arith_unit #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
`ifdef SEQ_ARITH_DIVZERO_EN
  ,
  output logic           div_zero
`endif
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARITH = 2'b01,
    S_ITER  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        state;
  logic [1:0]    op_r;
  logic [W:0]    acc;
  logic [W-1:0]  q;
  logic          qm1;
  logic [W:0]    m;
  logic [CW-1:0] cnt;

  logic [W:0]    booth_sum;
  logic [W:0]    booth_acc;
  logic [W-1:0]  booth_q;
  logic [W:0]    div_sh;
  logic [W+1:0]  div_t;
  logic          div_neg;
  logic [W:0]    div_acc;
  logic [W-1:0]  div_q;
  logic [W:0]    arith_sum;
  logic          last_iter;

  always_comb begin
    booth_sum = acc;
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[W], booth_sum[W:1]};
    booth_q   = {booth_sum[0], q[W-1:1]};

    // Shift, trial-subtract and restore all resolve within one iteration.
    div_sh  = {acc[W-1:0], q[W-1]};
    div_t   = {1'b0, div_sh} - {1'b0, m};
    div_neg = div_t[W+1];
    div_acc = div_neg ? div_sh : div_t[W:0];
    div_q   = {q[W-2:0], ~div_neg};

    if (op_r == OP_SUB) arith_sum = {q[W-1], q} - m;
    else                arith_sum = {q[W-1], q} + m;

    last_iter = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_r  <= OP_ADD;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      m     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
`ifdef SEQ_ARITH_DIVZERO_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r <= op;
            acc  <= '0;
            q    <= a;
            qm1  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
            m    <= (op == OP_DIV) ? {1'b0, b} : {b[W-1], b};
`ifdef SEQ_ARITH_DIVZERO_EN
            div_zero <= 1'b0;
            // Divide by zero reuses the one-cycle path so it reports with add/sub latency.
            if (op[1] == 1'b0 || (op == OP_DIV && b == '0)) state <= S_ARITH;
            else                                           state <= S_ITER;
`else
            if (op[1] == 1'b0) state <= S_ARITH;
            else               state <= S_ITER;
`endif
          end
        end

        S_ARITH: begin
`ifdef SEQ_ARITH_DIVZERO_EN
          if (op_r == OP_DIV) begin
            z        <= '0;
            div_zero <= 1'b1;
          end else begin
            z <= {{(W-1){arith_sum[W]}}, arith_sum};
          end
`else
          z <= {{(W-1){arith_sum[W]}}, arith_sum};
`endif
          done  <= 1'b1;
          state <= S_DONE;
        end

        S_ITER: begin
          if (op_r == OP_MUL) begin
            acc <= booth_acc;
            q   <= booth_q;
            qm1 <= q[0];
          end else begin
            acc <= div_acc;
            q   <= div_q;
          end
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            if (op_r == OP_MUL) z <= {booth_acc[W-1:0], booth_q};
            else                z <= {div_acc[W-1:0], div_q};
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (W=8); cycle 1 is the cycle after the start-sample edge.
// Honours SEQ_ARITH_DIVZERO_EN for the divide-by-zero expectations.
module tb_seq_arith_unit;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] z;
`ifdef SEQ_ARITH_DIVZERO_EN
  logic           div_zero;
`endif

  int errors = 0;
  int checks = 0;

  seq_arith_unit #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z)
`ifdef SEQ_ARITH_DIVZERO_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to done. inj_cyc>0 pulses a stray start in that cycle;
  // inj_done pulses one in the done cycle. Both must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [15:0] ez, input int elat,
                       input int inj_cyc, input bit inj_done);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    while (1) begin
      start = (lat == inj_cyc) || (inj_done && done);
      if (start) begin op = 2'b00; a = 8'h01; b = 8'h01; end
      if (done || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_z"}, 32'(z), 32'(ez));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    chk({tag, "_z_hold"}, 32'(z), 32'(ez));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
`ifdef SEQ_ARITH_DIVZERO_EN
    chk("rst_dz", 32'(div_zero), 32'd0);
`endif
    rst = 1'b0;

    do_op("add",     2'b00, 8'h64, 8'h64, 16'h00C8, 2, 0, 1'b0);
    do_op("add_max", 2'b00, 8'h7F, 8'h7F, 16'h00FE, 2, 0, 1'b0);
    do_op("sub",     2'b01, 8'h80, 8'h01, 16'hFF7F, 2, 0, 1'b0);
    do_op("sub_neg", 2'b01, 8'h00, 8'h80, 16'h0080, 2, 0, 1'b0);
    do_op("mul_min", 2'b10, 8'h80, 8'h80, 16'h4000, 9, 0, 1'b0);
    do_op("mul_neg", 2'b10, 8'hFD, 8'h07, 16'hFFEB, 9, 0, 1'b0);
    do_op("mul_max", 2'b10, 8'h7F, 8'h7F, 16'h3F01, 9, 0, 1'b0);
    do_op("div",     2'b11, 8'hC8, 8'h07, 16'h041C, 9, 0, 1'b0);
    do_op("div_sm",  2'b11, 8'h05, 8'h09, 16'h0500, 9, 0, 1'b0);
`ifdef SEQ_ARITH_DIVZERO_EN
    do_op("div0",    2'b11, 8'h2A, 8'h00, 16'h0000, 2, 0, 1'b0);
    chk("div0_flag", 32'(div_zero), 32'd1);
    do_op("after0",  2'b00, 8'h01, 8'h02, 16'h0003, 2, 0, 1'b0);
    chk("div0_flag_clr", 32'(div_zero), 32'd0);
`else
    do_op("div0",    2'b11, 8'h2A, 8'h00, 16'h2AFF, 9, 0, 1'b0);
`endif
    do_op("mul_inj", 2'b10, 8'h80, 8'h80, 16'h4000, 9, 4, 1'b1);
    chk("inj_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a multiply drops it and clears the result.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h03; b = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_z", 32'(z), 32'd0);
    rst = 1'b0;
    do_op("post_rst", 2'b10, 8'h03, 8'h05, 16'h000F, 9, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
